// File: rtl/quad_encoder_pkg.sv
// -----------------------------------------------------------------------------
// quad_encoder_pkg
// Shared constants and types for the quadrature encoder interface:
//   DEFAULT_CLOCK_FREQ : default system clock frequency in Hz
//   DATA_W             : width of the position / velocity words
//   step_t             : decoded quadrature step (+1 / 0 / -1 / illegal)
//   decode_step()      : maps previous and current filtered {A,B} to a step
// -----------------------------------------------------------------------------
package quad_encoder_pkg;

    localparam int unsigned DEFAULT_CLOCK_FREQ = 16_000_000;
    localparam int          DATA_W             = 24;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'b00,
        STEP_INC     = 2'b01,
        STEP_DEC     = 2'b10,
        STEP_ILLEGAL = 2'b11
    } step_t;

    // Forward rotation is 00 -> 01 -> 11 -> 10 -> 00. Any change of both
    // bits at once has no defined direction and is reported as illegal.
    function automatic step_t decode_step(input logic [1:0] prev,
                                          input logic [1:0] curr);
        step_t step;
        case ({prev, curr})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_INC;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_DEC;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = STEP_ILLEGAL;
            default:                                step = STEP_NONE;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// -----------------------------------------------------------------------------
// quad_filter
// One encoder channel: 2-flop synchronizer followed by a stability filter.
// The filtered level only follows the synchronized level after the two have
// disagreed for FILTER_LEN consecutive cycles.
// Ports:
//   CLK   : system clock
//   reset : asynchronous active-high reset (synchronizer and level go to 0)
//   pin   : raw channel input, asynchronous to CLK
//   level : debounced channel level
// -----------------------------------------------------------------------------
module quad_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic pin,
    output logic level
);

    logic       sync_meta;
    logic       sync_q;
    logic [3:0] count;

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= pin;
            sync_q    <= sync_meta;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count <= '0;
            level <= 1'b0;
        end else if (sync_q == level) begin
            count <= '0;
        end else if (count == 4'(FILTER_LEN - 1)) begin
            level <= sync_q;
            count <= '0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/quad_encoder.sv
// -----------------------------------------------------------------------------
// quad_encoder
// 4x quadrature decoder with input filtering, wrapping 24-bit position,
// sticky illegal-transition flag and windowed velocity measurement.
// Ports:
//   CLK            : system clock, all logic on its rising edge
//   reset          : asynchronous active-high reset
//   A, B           : encoder channels, asynchronous to CLK
//   zero           : synchronous clear of position, snapshot and error
//   position       : signed accumulated count (wraps modulo 2^24)
//   velocity       : position change over the last velocity window
//   velocity_valid : one-cycle pulse when velocity updates
//   error          : sticky flag for a two-bit transition
// -----------------------------------------------------------------------------
module quad_encoder
    import quad_encoder_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = DEFAULT_CLOCK_FREQ,
    parameter int unsigned VELOCITY_FREQ = 1000,
    parameter int unsigned FILTER_LEN    = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     A,
    input  logic                     B,
    input  logic                     zero,
    output logic signed [DATA_W-1:0] position,
    output logic signed [DATA_W-1:0] velocity,
    output logic                     velocity_valid,
    output logic                     error
);

    localparam int unsigned WINDOW = CLOCK_FREQ / VELOCITY_FREQ;
    localparam int unsigned WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic                     level_a;
    logic                     level_b;
    logic [1:0]               curr_level;
    logic [1:0]               prev_level;
    step_t                    step;
    logic [WIN_W-1:0]         win_count;
    logic                     terminal;
    logic signed [DATA_W-1:0] snapshot;

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_a (
        .CLK   (CLK),
        .reset (reset),
        .pin   (A),
        .level (level_a)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_b (
        .CLK   (CLK),
        .reset (reset),
        .pin   (B),
        .level (level_b)
    );

    assign curr_level = {level_a, level_b};
    assign step       = decode_step(prev_level, curr_level);
    assign terminal   = (win_count == WIN_W'(WINDOW - 1));

    // prev_level resets to 00, so the first accepted level after reset is
    // decoded as an ordinary transition out of 00.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prev_level <= 2'b00;
            position   <= '0;
            error      <= 1'b0;
        end else begin
            prev_level <= curr_level;
            if (zero) begin
                position <= '0;
                error    <= 1'b0;
            end else begin
                // NOTE: the empty default keeps the case full; position and
                // error simply hold, no latch is involved in a clocked block.
                case (step)
                    STEP_INC:     position <= position + DATA_W'(1);
                    STEP_DEC:     position <= position - DATA_W'(1);
                    STEP_ILLEGAL: error    <= 1'b1;
                    default:      ;
                endcase
            end
        end
    end

    // Velocity is taken from the registered position, so a step landing on
    // the terminal cycle is counted in the following window.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            win_count      <= '0;
            velocity       <= '0;
            velocity_valid <= 1'b0;
            snapshot       <= '0;
        end else begin
            velocity_valid <= terminal;
            win_count      <= terminal ? '0 : win_count + WIN_W'(1);
            if (terminal) begin
                velocity <= position - snapshot;
            end
            if (zero) begin
                snapshot <= '0;
            end else if (terminal) begin
                snapshot <= position;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder
// Directed scenarios plus a randomized run checked against a behavioural
// model. The model works from pin samples: it delays them by the
// synchronizer depth, applies the consecutive-cycle acceptance rule, and
// turns level changes into steps through Gray-to-binary arithmetic.
// -----------------------------------------------------------------------------
module tb_quad_encoder;

    localparam int CLOCK_FREQ    = 1_000_000;
    localparam int VELOCITY_FREQ = 1000;
    localparam int FILTER_LEN    = 4;
    localparam int WINDOW        = CLOCK_FREQ / VELOCITY_FREQ;

    logic               clk   = 1'b0;
    logic               reset = 1'b0;
    logic               a     = 1'b0;
    logic               b     = 1'b0;
    logic               zero  = 1'b0;
    logic signed [23:0] position;
    logic signed [23:0] velocity;
    logic               velocity_valid;
    logic               error;

    int checks = 0;
    int passes = 0;

    quad_encoder #(
        .CLOCK_FREQ    (CLOCK_FREQ),
        .VELOCITY_FREQ (VELOCITY_FREQ),
        .FILTER_LEN    (FILTER_LEN)
    ) dut (
        .CLK            (clk),
        .reset          (reset),
        .A              (a),
        .B              (b),
        .zero           (zero),
        .position       (position),
        .velocity       (velocity),
        .velocity_valid (velocity_valid),
        .error          (error)
    );

    initial forever #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit [1:0]  hist0;     // pins sampled one edge ago
        bit [1:0]  hist1;     // pins sampled two edges ago
        bit [1:0]  lvl;       // accepted levels {A,B}
        bit [1:0]  prev_lvl;
        int        cnt_a;
        int        cnt_b;
        bit [23:0] pos;
        bit [23:0] snap;
        bit [23:0] vel;
        bit        valid;
        bit        err;
        int        win;
    } model_t;

    model_t m;

    // Position of a Gray-coded {A,B} pair along the forward sequence.
    function automatic int gidx(input bit [1:0] x);
        return int'({x[1], x[1] ^ x[0]});
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.hist0 = 2'b00; r.hist1 = 2'b00; r.lvl = 2'b00; r.prev_lvl = 2'b00;
        r.cnt_a = 0; r.cnt_b = 0;
        r.pos = '0; r.snap = '0; r.vel = '0;
        r.valid = 1'b0; r.err = 1'b0; r.win = 0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t cur, input bit pa,
                                          input bit pb, input bit z);
        model_t n;
        int     d;
        n = cur;
        n.valid = 1'b0;
        if (cur.win == WINDOW - 1) begin
            n.vel   = cur.pos - cur.snap;
            n.snap  = cur.pos;
            n.valid = 1'b1;
            n.win   = 0;
        end else begin
            n.win = cur.win + 1;
        end
        d = (gidx(cur.lvl) - gidx(cur.prev_lvl)) & 3;
        if (z) begin
            n.pos  = '0;
            n.snap = '0;
            n.err  = 1'b0;
        end else if (d == 1) begin
            n.pos = cur.pos + 24'd1;
        end else if (d == 3) begin
            n.pos = cur.pos - 24'd1;
        end else if (d == 2) begin
            n.err = 1'b1;
        end
        n.prev_lvl = cur.lvl;
        if (cur.hist1[1] == cur.lvl[1]) n.cnt_a = 0;
        else if (cur.cnt_a + 1 == FILTER_LEN) begin
            n.lvl[1] = cur.hist1[1];
            n.cnt_a  = 0;
        end else n.cnt_a = cur.cnt_a + 1;
        if (cur.hist1[0] == cur.lvl[0]) n.cnt_b = 0;
        else if (cur.cnt_b + 1 == FILTER_LEN) begin
            n.lvl[0] = cur.hist1[0];
            n.cnt_b  = 0;
        end else n.cnt_b = cur.cnt_b + 1;
        n.hist1 = cur.hist0;
        n.hist0 = {pa, pb};
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, a, b, zero);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // dir = +1 forward, -1 reverse, one quadrature state from current pins.
    task automatic move(input int dir);
        int idx;
        idx = (gidx({a, b}) + dir) & 3;
        a = idx[1];
        b = idx[1] ^ idx[0];
    endtask

    task automatic pulse_zero();
        zero = 1'b1;
        tick(1);
        zero = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 reset = 1'b1;
        tick(3);
        checks++; if (position !== 24'd0) $display("FAIL reset_position got %h want 000000", position); else passes++;
        checks++; if (velocity !== 24'd0) $display("FAIL reset_velocity got %h want 000000", velocity); else passes++;
        checks++; if (velocity_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", velocity_valid); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else passes++;
        reset = 1'b0;
        tick(10);
    endtask

    task automatic test_forward_latency();
        pulse_zero();
        tick(10);
        for (int s = 1; s <= 16; s++) begin
            move(1);
            tick(FILTER_LEN + 2);
            checks++; if (position !== 24'(s - 1)) $display("FAIL fwd_before_edge step %0d got %0d want %0d", s, position, s - 1); else passes++;
            tick(1);
            checks++; if (position !== 24'(s)) $display("FAIL fwd_at_edge step %0d got %0d want %0d", s, position, s); else passes++;
            tick(20 - FILTER_LEN - 3);
        end
        checks++; if (position !== 24'd16) $display("FAIL fwd_total got %0d want 16", position); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL fwd_error got %b want 0", error); else passes++;
    endtask

    task automatic test_glitch();
        pulse_zero();
        a = 1'b1; tick(FILTER_LEN - 1); a = 1'b0;
        tick(15);
        checks++; if (position !== 24'd0) $display("FAIL glitch_short got %0d want 0", position); else passes++;
        move(1);                       // 00 -> 01
        tick(20);
        checks++; if (position !== 24'd1) $display("FAIL glitch_setup got %0d want 1", position); else passes++;
        a = 1'b1; tick(FILTER_LEN); a = 1'b0;   // 01 -> 11 -> 01
        tick(4);
        checks++; if (position !== 24'd2) $display("FAIL glitch_pulse_up got %0d want 2", position); else passes++;
        tick(16);
        checks++; if (position !== 24'd1) $display("FAIL glitch_pulse_down got %0d want 1", position); else passes++;
        move(-1);
        tick(20);
        checks++; if (position !== 24'd0) $display("FAIL glitch_return got %0d want 0", position); else passes++;
    endtask

    task automatic test_wrap_and_zero();
        move(-1);
        tick(20);
        checks++; if (position !== 24'hFFFFFF) $display("FAIL wrap_under got %h want ffffff", position); else passes++;
        move(1);
        tick(20);
        checks++; if (position !== 24'h000000) $display("FAIL wrap_over got %h want 000000", position); else passes++;
        move(-1); tick(20); move(-1); tick(20);
        checks++; if (position !== 24'hFFFFFE) $display("FAIL wrap_two_down got %h want fffffe", position); else passes++;
        pulse_zero();
        checks++; if (position !== 24'd0) $display("FAIL zero_next_cycle got %h want 000000", position); else passes++;
        // Zero lands on the same edge the step reaches position.
        move(1);
        tick(FILTER_LEN + 2);
        zero = 1'b1; tick(1); zero = 1'b0;
        checks++; if (position !== 24'd0) $display("FAIL zero_priority got %h want 000000", position); else passes++;
        tick(20);
        checks++; if (position !== 24'd0) $display("FAIL zero_step_dropped got %h want 000000", position); else passes++;
    endtask

    task automatic test_illegal();
        move(1);                       // back to 00, position 1
        tick(20);
        checks++; if (position !== 24'd1) $display("FAIL illegal_setup got %0d want 1", position); else passes++;
        a = 1'b1; b = 1'b1;            // 00 -> 11
        tick(20);
        checks++; if (position !== 24'd1) $display("FAIL illegal_pos got %0d want 1", position); else passes++;
        checks++; if (error !== 1'b1) $display("FAIL illegal_error got %b want 1", error); else passes++;
        tick(50);
        checks++; if (error !== 1'b1) $display("FAIL illegal_sticky got %b want 1", error); else passes++;
        a = 1'b0; b = 1'b0;            // 11 -> 00
        tick(20);
        checks++; if (position !== 24'd1) $display("FAIL illegal_back_pos got %0d want 1", position); else passes++;
        pulse_zero();
        checks++; if (error !== 1'b0) $display("FAIL illegal_cleared got %b want 0", error); else passes++;
        checks++; if (position !== 24'd0) $display("FAIL illegal_zero_pos got %0d want 0", position); else passes++;
    endtask

    task automatic run_velocity(input int dir, input logic signed [23:0] want, input string tag);
        int                 last_pulse;
        int                 prev_pulse;
        int                 pulses;
        logic signed [23:0] last_vel;
        bit                 double_pulse;
        bit                 prev_v;
        last_pulse = -1; prev_pulse = -1; pulses = 0; last_vel = '0;
        double_pulse = 1'b0; prev_v = 1'b0;
        for (int i = 0; i < 2600; i++) begin
            if (i % 20 == 0) move(dir);
            tick(1);
            if (velocity_valid === 1'b1) begin
                if (prev_v) double_pulse = 1'b1;
                prev_pulse = last_pulse;
                last_pulse = i;
                pulses++;
                last_vel = velocity;
            end
            prev_v = (velocity_valid === 1'b1);
        end
        checks++; if (pulses < 2) $display("FAIL %s_pulse_count got %0d want >=2", tag, pulses); else passes++;
        checks++; if (last_pulse - prev_pulse != WINDOW) $display("FAIL %s_period got %0d want %0d", tag, last_pulse - prev_pulse, WINDOW); else passes++;
        checks++; if (double_pulse) $display("FAIL %s_pulse_width got >1 cycle want 1", tag); else passes++;
        checks++; if (last_vel !== want) $display("FAIL %s_value got %0d want %0d", tag, last_vel, want); else passes++;
    endtask

    task automatic test_velocity();
        pulse_zero();
        run_velocity(1, 24'sd50, "vel_fwd");
        run_velocity(-1, -24'sd50, "vel_rev");
    endtask

    task automatic test_reset_mid_window();
        bit found;
        int k_found;
        found = 1'b0;
        for (int k = 0; k < WINDOW + 100 && !found; k++) begin
            tick(1);
            if (velocity_valid === 1'b1) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL rstwin_align got no pulse want pulse within %0d cycles", WINDOW + 100); else passes++;
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) move(1);
            tick(1);
        end
        reset = 1'b1;
        a = 1'b0; b = 1'b0;
        tick(2);
        checks++; if (position !== 24'd0) $display("FAIL rstwin_position got %h want 000000", position); else passes++;
        checks++; if (velocity !== 24'd0) $display("FAIL rstwin_velocity got %h want 000000", velocity); else passes++;
        checks++; if (velocity_valid !== 1'b0) $display("FAIL rstwin_valid got %b want 0", velocity_valid); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL rstwin_error got %b want 0", error); else passes++;
        reset = 1'b0;
        found = 1'b0; k_found = 0;
        for (int k = 1; k <= WINDOW + 100 && !found; k++) begin
            tick(1);
            if (velocity_valid === 1'b1) begin
                found = 1'b1;
                k_found = k;
            end
        end
        checks++; if (k_found != WINDOW) $display("FAIL rstwin_first_pulse got %0d want %0d", k_found, WINDOW); else passes++;
        checks++; if (velocity !== 24'd0) $display("FAIL rstwin_first_velocity got %0d want 0", velocity); else passes++;
    endtask

    task automatic test_random();
        int r;
        int shown;
        shown = 0;
        for (int i = 0; i < 4000; i++) begin
            zero = 1'b0;
            r = int'($urandom_range(0, 399));
            if      (r < 25) move(1);
            else if (r < 50) move(-1);
            else if (r < 56) a = ~a;
            else if (r < 60) b = ~b;
            else if (r < 62) begin a = ~a; b = ~b; end
            else if (r == 62) zero = 1'b1;
            tick(1);
            checks++;
            if (position !== m.pos) begin
                if (shown < 20) $display("FAIL rand_position cycle %0d got %h want %h", i, position, m.pos);
                shown++;
            end else passes++;
            checks++;
            if (error !== m.err) begin
                if (shown < 20) $display("FAIL rand_error cycle %0d got %b want %b", i, error, m.err);
                shown++;
            end else passes++;
            checks++;
            if (velocity_valid !== m.valid) begin
                if (shown < 20) $display("FAIL rand_valid cycle %0d got %b want %b", i, velocity_valid, m.valid);
                shown++;
            end else passes++;
            checks++;
            if (velocity !== m.vel) begin
                if (shown < 20) $display("FAIL rand_velocity cycle %0d got %h want %h", i, velocity, m.vel);
                shown++;
            end else passes++;
        end
        zero = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward_latency();
        test_glitch();
        test_wrap_and_zero();
        test_illegal();
        test_velocity();
        test_reset_mid_window();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
